// File: rtl/logic_eval_pkg.sv
// Shared types and the evaluated function for the logic_eval_arbiter slice.
// The bench reuses logic_eval_f so design and model agree on one definition.
package logic_eval_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  function automatic logic logic_eval_f(input logic a, input logic b, input logic c);
    return a & (b | c);
  endfunction

endpackage

// File: rtl/logic_eval_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// The pointer register lives in the parent so this block stays stateless.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    winner,
  output logic               grant_valid
);

  always_comb begin
    int idx;
    grant       = '0;
    winner      = '0;
    grant_valid = 1'b0;
    idx         = 0;
    if (en) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        // ptr is always kept below NUM_REQ, so one subtraction wraps correctly
        idx = int'(ptr) + i;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!grant_valid && req[idx]) begin
          grant_valid = 1'b1;
          grant[idx]  = 1'b1;
          winner      = ID_W'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/logic_eval_arbiter.sv
// Shares one a & (b | c) evaluation among NUM_REQ requesters through a
// round-robin grant and a single-entry registered response slot.
module logic_eval_arbiter
  import logic_eval_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [NUM_REQ-1:0] req_a,
  input  logic [NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0] req_c,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_result,
  output logic [ID_W-1:0]    rsp_id,
  output logic [CNT_W-1:0]   eval_count
);

  slot_state_t     state_q, state_d;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] winner;
  logic            grant_valid;
  logic            slot_free;

  assign rsp_valid = (state_q == FULL);
  assign slot_free = (state_q == EMPTY) || rsp_ready;

  // Gating with rst keeps every ready low during the reset cycle itself
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req         (req_valid),
    .ptr         (rr_ptr),
    .en          (slot_free && !rst),
    .grant       (req_ready),
    .winner      (winner),
    .grant_valid (grant_valid)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (grant_valid) state_d = FULL;
      FULL:    if (grant_valid) state_d = FULL;
               else if (rsp_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      rsp_result <= 1'b0;
      rsp_id     <= '0;
      rr_ptr     <= '0;
      eval_count <= '0;
    end else begin
      state_q <= state_d;
      if (grant_valid) begin
        rsp_result <= logic_eval_f(req_a[winner], req_b[winner], req_c[winner]);
        rsp_id     <= winner;
        rr_ptr     <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end
      if (rsp_valid && rsp_ready) eval_count <= eval_count + 1'b1;
    end
  end

endmodule

// File: doc/logic_eval_arbiter.md
# logic_eval_arbiter

Shares one evaluation of the `Result = a & (b | c)` function among `NUM_REQ` requesters. Each requester presents an `a`/`b`/`c` operand triple with a valid/ready handshake. A round-robin arbiter grants one requester per cycle and the function result is registered into a single-entry output slot. The response carries the winner's index back to the consumer. The block sits between the requesting agents and the shared logic-evaluation resource, and it owns all sequencing and fairness for that resource.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester index.
- `CNT_W`, default 16: width of the completed-evaluation counter.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: sole clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, NUM_REQ: per-requester operand valid.
- `req_ready`, out, NUM_REQ: per-requester grant/accept; at most one bit high.
- `req_a`, `req_b`, `req_c`, in, NUM_REQ each: operand bit i belongs to requester i.
- `rsp_valid`, out, 1: output slot holds a result.
- `rsp_ready`, in, 1: consumer accepts the result.
- `rsp_result`, out, 1: `a & (b | c)` of the granted requester.
- `rsp_id`, out, ID_W: index of the granted requester.
- `eval_count`, out, CNT_W: number of completed response handshakes.

## Operation
- Output slot FSM:
  - EMPTY: `rsp_valid`=0.
  - FULL: `rsp_valid`=1.
- `slot_free` = EMPTY, or FULL with `rsp_ready`=1 (same-cycle drain and refill is allowed).
- Arbitration runs only when `slot_free`.
  - Candidates are the set bits of `req_valid`.
  - The winner is the first set bit scanning from `rr_ptr` upward, wrapping modulo NUM_REQ.
- Grant is combinational: `req_ready[w]`=1 for the winner only, and only when `slot_free` and any `req_valid` is set. All `req_ready` bits are 0 otherwise.
  - This logic depends on `req_valid` and on state. It must not depend on `req_ready` feedback.
- On a grant, at the next edge:
  - `rsp_result` ← `a[w] & (b[w] | c[w])`
  - `rsp_id` ← w
  - FSM → FULL
  - `rr_ptr` ← (w+1) mod NUM_REQ
- With no grant and `rsp_ready`=1 in FULL: FSM → EMPTY. `rsp_result`/`rsp_id` keep their last values (don't-care while `rsp_valid`=0).
- While FULL and `rsp_ready`=0: `rsp_result` and `rsp_id` are held stable and no grant is issued.
- `rr_ptr` updates only on a grant. With no requests it stays where it is.
- `eval_count` increments by 1 on each `rsp_valid & rsp_ready`. It wraps from 2^CNT_W−1 to 0 with no saturation.
- Requesters may drop `req_valid` without a grant. The block holds no state about a request until it grants it.

## Timing
- Latency: grant cycle N → `rsp_valid` at cycle N+1.
- Sustained throughput: one evaluation per cycle while `rsp_ready`=1.
- Reset values:
  - FSM = EMPTY, `rsp_valid`=0
  - `rsp_result`=0, `rsp_id`=0
  - `rr_ptr`=0, `eval_count`=0
  - `req_ready` = all 0 during the reset cycle.
- `rst` takes priority over every other event in the same cycle. Any pending result is discarded and no handshake completes.
- Single requester held high: it is granted every cycle the slot is free, so there is no starvation of itself.
- All NUM_REQ requesting continuously: each requester is granted exactly once per NUM_REQ grants.

## Structure
- Shared package `logic_eval_pkg`:
  - `slot_state_t` enum {EMPTY, FULL}
  - function `logic_eval_f(a, b, c)` returning `a & (b | c)`, reused by the bench model.
- One sub-module is natural: `rr_arbiter`, parameterised by NUM_REQ.
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant and encoded winner index.
  - Purely combinational; the pointer register stays in the top.

## Test plan
- Reset, then all `req_valid`=0 for 10 cycles → `rsp_valid`=0, all `req_ready`=0, `eval_count`=0.
- Requester 2 only, a=1,b=0,c=1, `rsp_ready`=1 → `req_ready`=4'b0100 at cycle N; at N+1 `rsp_valid`=1, `rsp_result`=1, `rsp_id`=2; `eval_count`=1 after the handshake.
- All four requesting continuously, `rsp_ready`=1 → `rsp_id` sequence 0,1,2,3,0,1…; all 8 operand combinations checked against `logic_eval_f` (e.g. a=1,b=0,c=0 → 0).
- Backpressure: result held with `rsp_ready`=0 for 5 cycles → `rsp_result`/`rsp_id` stable, `req_ready`=0. Release → the next grant occurs in the same cycle as the drain.
- `rst` asserted while FULL with `rsp_ready`=1 → next cycle `rsp_valid`=0, `eval_count` unchanged at 0 / reset value, `rr_ptr`=0 (next grant goes to requester 0 when all request).
- Force `eval_count` near wrap (CNT_W=4 build): 16 handshakes → count returns to 0.
